// File: rtl/quad_encoder_counter.sv
// Quadrature encoder front end: input sync, glitch filter, 4x decode,
// signed position counter, direction with idle timeout, illegal-edge flag.
module quad_encoder_counter #(
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int IDLE_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 A,
    input  logic                 B,
    output logic [1:0]           dir,
    output logic [CNT_WIDTH-1:0] position,
    output logic                 step,
    output logic                 err
);

    localparam int FW       = $clog2(FILTER_LEN + 1);
    localparam int IW       = $clog2(IDLE_CYCLES + 1);
    localparam int INIT_LEN = SYNC_STAGES + FILTER_LEN;
    localparam int NW       = $clog2(INIT_LEN + 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sa_q, sa_d, sb_q, sb_d;
    logic [1:0]             f_q, f_d, p_q, p_d;
    logic [1:0][FW-1:0]     fc_q, fc_d;
    logic [NW-1:0]          init_q, init_d;
    logic [IW-1:0]          idle_q, idle_d;
    logic [CNT_WIDTH-1:0]   pos_q, pos_d;
    logic [1:0]             dir_q, dir_d;
    logic                   step_q, step_d;
    logic                   err_q, err_d;
    logic [1:0]             s;
    logic [1:0]             delta;

    // Gray-coded {A,B} to quadrature phase: 00->0, 10->1, 11->2, 01->3
    function automatic logic [1:0] phase(input logic [1:0] ab);
        return {ab[0], ab[1] ^ ab[0]};
    endfunction

    always_comb begin
        state_d = state_q;
        sa_d    = {sa_q[SYNC_STAGES-2:0], A};
        sb_d    = {sb_q[SYNC_STAGES-2:0], B};
        f_d     = f_q;
        p_d     = f_q;
        fc_d    = fc_q;
        init_d  = init_q;
        idle_d  = idle_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        err_d   = err_q;
        s       = {sa_q[SYNC_STAGES-1], sb_q[SYNC_STAGES-1]};
        delta   = phase(f_q) - phase(p_q);

        unique case (state_q)
            INIT: begin
                // Track the resting level so a non-00 start neither counts nor errors
                f_d  = s;
                fc_d = '0;
                if (init_q == NW'(INIT_LEN - 1)) begin
                    state_d = RUN;
                    init_d  = '0;
                end else begin
                    init_d = init_q + NW'(1);
                end
            end
            RUN: begin
                for (int i = 0; i < 2; i++) begin
                    if (s[i] == f_q[i]) begin
                        fc_d[i] = '0;
                    end else if (fc_q[i] == FW'(FILTER_LEN - 1)) begin
                        f_d[i]  = s[i];
                        fc_d[i] = '0;
                    end else begin
                        fc_d[i] = fc_q[i] + FW'(1);
                    end
                end

                if (f_q != p_q) begin
                    case (delta)
                        2'd1: begin
                            pos_d  = pos_q + CNT_WIDTH'(1);
                            step_d = 1'b1;
                            dir_d  = 2'b01;
                            idle_d = IW'(IDLE_CYCLES);
                        end
                        2'd3: begin
                            pos_d  = pos_q - CNT_WIDTH'(1);
                            step_d = 1'b1;
                            dir_d  = 2'b10;
                            idle_d = IW'(IDLE_CYCLES);
                        end
                        default: err_d = 1'b1;
                    endcase
                end

                if (!step_d && idle_q != '0) begin
                    idle_d = idle_q - IW'(1);
                    if (idle_q == IW'(1)) begin
                        dir_d = 2'b00;
                    end
                end

                if (clr) begin
                    pos_d = '0;
                    err_d = 1'b0;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            sa_q    <= '0;
            sb_q    <= '0;
            f_q     <= '0;
            p_q     <= '0;
            fc_q    <= '0;
            init_q  <= '0;
            idle_q  <= '0;
            pos_q   <= '0;
            dir_q   <= '0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            f_q     <= f_d;
            p_q     <= p_d;
            fc_q    <= fc_d;
            init_q  <= init_d;
            idle_q  <= idle_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    assign dir      = dir_q;
    assign position = pos_q;
    assign step     = step_q;
    assign err      = err_q;

endmodule
